fp_rnd_pipe: RTL
================

Name: fp_rnd_pipe

Overview:
- Pipelined rounding and packing unit; consumer side of the fp_rnd record emitted by the conversion and arithmetic datapaths.
- Takes sign, biased exponent, pre-normalised mantissa, guard/round/sticky bits, rounding mode and special-case flags, and produces a packed IEEE-754 single (NaN-boxed) or double result plus RISC-V fflags.
- Two register stages with valid/ready handshake on both sides so it can sit between an issue stage and the writeback buffer.

Parameters:
- STAGES, 2, fixed pipeline depth; only 2 is supported.

Ports:
- clock  in  1  clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; clears both stage valids on the next edge
- in_valid  in  1  input record valid
- in_ready  out  1  unit can accept a record this cycle
- in_sig  in  1  sign
- in_expo  in  14  biased exponent, unsigned; 0 means subnormal
- in_mant  in  54  mantissa; hidden bit at [23] for single, [52] for double
- in_grs  in  3  {guard, round, sticky}
- in_rm  in  3  0 rne, 1 rtz, 2 rdn, 3 rup, 4 rmm
- in_fmt  in  2  0 single, 1 double
- in_snan, in_qnan, in_dbz, in_inf, in_zero  in  1 each  special-case flags
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_result  out  64  packed result
- out_flags  out  5  {NV, DZ, OF, UF, NX}

Behaviour:
- Reset: s1_valid = s2_valid = 0; out_valid = 0, out_result = 0, out_flags = 0.
- Handshake:
  - Transfer occurs when valid & ready.
  - Stage 2 advances when ~s2_valid | out_ready.
  - Stage 1 advances when ~s1_valid | stage 2 advances.
  - in_ready = ~s1_valid | stage 2 advances. This is a combinational path from out_ready and is allowed.
- Latency: result valid 2 cycles after input acceptance with no backpressure. Full throughput is 1 per cycle. Order is preserved. Held outputs stay stable while out_valid & ~out_ready.
- Stage 1 computes inc:
  - rne: g & (lsb | r | s)
  - rtz: 0
  - rdn: sig & |grs
  - rup: ~sig & |grs
  - rmm: g
  - rm values 5-7 are treated as rne.
  - Stage 1 registers the record plus inc and inexact = |grs.
- Stage 2 rounding and normalisation:
  - mant_r = mant + inc, at 55-bit width.
  - If mant_r carries past the hidden bit (bit 24 single / 53 double): shift right 1, expo + 1.
  - If expo = 0 and mant_r hidden bit is set: expo = 1 (subnormal rounds to normal).
- Overflow is expo_r >= 255 (single) / 2047 (double). It raises OF|NX. Result by rm:
  - rne, rmm: inf.
  - rtz: max finite.
  - rdn: inf if negative, else max finite.
  - rup: inf if positive, else max finite.
- Underflow: UF = inexact & expo_r == 0 (tininess after rounding). NX = inexact | overflow.
- Special-case priority: snan > qnan > dbz > inf > zero > normal path.
  - snan: canonical NaN, NV only.
  - qnan: canonical NaN, no flags.
  - dbz: signed inf, DZ.
  - inf: signed inf, no flags.
  - zero: signed zero, no flags.
- Canonical NaN: 0x7FC00000 (single) / 0x7FF8000000000000 (double).
- Packing: single results are NaN-boxed, so out_result[63:32] = 0xFFFFFFFF. Fraction field excludes the hidden bit.
- flush: both valids are 0 after the edge. An input presented in the flush cycle is dropped. flush has priority over acceptance.
- Reset mid-operation: all in-flight records are discarded immediately (asynchronous); nothing is emitted after release until new input is accepted.

Test Plan:
- Single basic: single, expo 127, mant 0x800000, grs 000, rm 0 -> out_result 0xFFFFFFFF3F800000, flags 0x00, out_valid exactly 2 cycles after acceptance.
- RNE tie: double, expo 1023, mant 0x10000000000001, grs 100, rm 0 -> 0x3FF0000000000002, flags 0x01. Same input with mant 0x10000000000000 -> 0x3FF0000000000000, flags 0x01.
- Mantissa carry: single, expo 127, mant 0xFFFFFF, grs 110, rm 0 -> 0xFFFFFFFF40000000, flags 0x01. Subnormal case: expo 0, mant 0x7FFFFF, grs 100, rm 0 -> 0xFFFFFFFF00800000, flags 0x01.
- Overflow: single, expo 255, mant 0x800000, grs 000:
  - rm 1 -> 0xFFFFFFFF7F7FFFFF, flags 0x05.
  - rm 0 -> 0xFFFFFFFF7F800000, flags 0x05.
  - sig 1, rm 3 -> 0xFFFFFFFFFF7FFFFF.
- Specials:
  - snan, double -> 0x7FF8000000000000, flags 0x10.
  - dbz, sig 1, single -> 0xFFFFFFFFFF800000, flags 0x08.
  - zero, sig 1, double -> 0x8000000000000000, flags 0x00.
- Backpressure, flush and reset:
  - Drive 4 back-to-back records with out_ready = 0 -> in_ready = 0 after 2 accepted. Release out_ready -> all 4 results emitted in order, none lost or duplicated.
  - Assert flush with 2 in flight -> out_valid = 0 next cycle.
  - Assert reset mid-stream -> out_valid = 0 immediately.

Source files
------------

// File: rtl/fp_rnd_pipe.sv
// fp_rnd_pipe: two-stage rounding and packing unit for the fp_rnd record.
// Stage 1 decides the rounding increment, stage 2 rounds, normalises and packs.
module fp_rnd_pipe #(
   parameter int STAGES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sig,
   input  logic [13:0] in_expo,
   input  logic [53:0] in_mant,
   input  logic [2:0]  in_grs,
   input  logic [2:0]  in_rm,
   input  logic [1:0]  in_fmt,
   input  logic        in_snan,
   input  logic        in_qnan,
   input  logic        in_dbz,
   input  logic        in_inf,
   input  logic        in_zero,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [63:0] out_result,
   output logic [4:0]  out_flags
);

   localparam logic [2:0] RM_RTZ = 3'd1;
   localparam logic [2:0] RM_RDN = 3'd2;
   localparam logic [2:0] RM_RUP = 3'd3;
   localparam logic [2:0] RM_RMM = 3'd4;

   typedef struct packed {
      logic        sig;
      logic [13:0] expo;
      logic [53:0] mant;
      logic [2:0]  rm;
      logic        dbl;
      logic        snan;
      logic        qnan;
      logic        dbz;
      logic        inf;
      logic        zero;
      logic        inc;
      logic        inexact;
   } s1_rec_t;

   logic [STAGES:1] vld_pipe;
   logic            s1_adv;
   logic            s2_adv;
   s1_rec_t         s1_d;
   s1_rec_t         s1_q;
   logic [63:0]     s2_result;
   logic [4:0]      s2_flags;

   assign s2_adv    = ~vld_pipe[STAGES] | out_ready;
   assign s1_adv    = ~vld_pipe[1] | s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = vld_pipe[STAGES];
   assign out_result = s2_result;
   assign out_flags  = s2_flags;

   // ---------------- stage 1: rounding decision ----------------
   logic g_bit, r_bit, s_bit, inc_d;
   assign {g_bit, r_bit, s_bit} = in_grs;

   always_comb begin
      inc_d = g_bit & (in_mant[0] | r_bit | s_bit);
      case (in_rm)
         RM_RTZ:  inc_d = 1'b0;
         RM_RDN:  inc_d = in_sig & (|in_grs);
         RM_RUP:  inc_d = ~in_sig & (|in_grs);
         RM_RMM:  inc_d = g_bit;
         default: ;
      endcase
   end

   always_comb begin
      s1_d         = '0;
      s1_d.sig     = in_sig;
      s1_d.expo    = in_expo;
      s1_d.mant    = in_mant;
      s1_d.rm      = in_rm;
      s1_d.dbl     = (in_fmt == 2'd1);
      s1_d.snan    = in_snan;
      s1_d.qnan    = in_qnan;
      s1_d.dbz     = in_dbz;
      s1_d.inf     = in_inf;
      s1_d.zero    = in_zero;
      s1_d.inc     = inc_d;
      s1_d.inexact = |in_grs;
   end

   // ---------------- stage 2: round, normalise, pack ----------------
   logic [54:0] mant_r, mant_n;
   logic [14:0] expo_c, expo_r;
   logic        hid_carry, hid_set, ovf, ovf_inf;
   logic [63:0] inf_w, max_w, nan_w, zero_w, norm_w, res_d;
   logic [4:0]  flags_d;

   always_comb begin
      mant_r    = {1'b0, s1_q.mant} + {54'd0, s1_q.inc};
      hid_carry = s1_q.dbl ? mant_r[53] : mant_r[24];
      mant_n    = hid_carry ? (mant_r >> 1) : mant_r;
      expo_c    = {1'b0, s1_q.expo} + {14'd0, hid_carry};
      hid_set   = s1_q.dbl ? mant_n[52] : mant_n[23];
      // a subnormal that rounds up into the hidden bit becomes the smallest normal
      expo_r    = (expo_c == 15'd0 && hid_set) ? 15'd1 : expo_c;
      ovf       = s1_q.dbl ? (expo_r >= 15'd2047) : (expo_r >= 15'd255);
   end

   always_comb begin
      ovf_inf = 1'b1;
      case (s1_q.rm)
         RM_RTZ:  ovf_inf = 1'b0;
         RM_RDN:  ovf_inf = s1_q.sig;
         RM_RUP:  ovf_inf = ~s1_q.sig;
         default: ;
      endcase
   end

   // single results carry the NaN-box in the upper word
   always_comb begin
      if (s1_q.dbl) begin
         inf_w  = {s1_q.sig, 11'h7FF, 52'd0};
         max_w  = {s1_q.sig, 11'h7FE, {52{1'b1}}};
         nan_w  = 64'h7FF8_0000_0000_0000;
         zero_w = {s1_q.sig, 63'd0};
         norm_w = {s1_q.sig, expo_r[10:0], mant_n[51:0]};
      end else begin
         inf_w  = {32'hFFFF_FFFF, s1_q.sig, 8'hFF, 23'd0};
         max_w  = {32'hFFFF_FFFF, s1_q.sig, 8'hFE, {23{1'b1}}};
         nan_w  = 64'hFFFF_FFFF_7FC0_0000;
         zero_w = {32'hFFFF_FFFF, s1_q.sig, 31'd0};
         norm_w = {32'hFFFF_FFFF, s1_q.sig, expo_r[7:0], mant_n[22:0]};
      end
   end

   always_comb begin
      res_d   = norm_w;
      flags_d = {2'b00, ovf, s1_q.inexact & (expo_r == 15'd0), s1_q.inexact | ovf};
      if (s1_q.snan) begin
         res_d   = nan_w;
         flags_d = 5'b10000;
      end else if (s1_q.qnan) begin
         res_d   = nan_w;
         flags_d = 5'b00000;
      end else if (s1_q.dbz) begin
         res_d   = inf_w;
         flags_d = 5'b01000;
      end else if (s1_q.inf) begin
         res_d   = inf_w;
         flags_d = 5'b00000;
      end else if (s1_q.zero) begin
         res_d   = zero_w;
         flags_d = 5'b00000;
      end else if (ovf) begin
         res_d   = ovf_inf ? inf_w : max_w;
      end
   end

   logic unused_bits;
   assign unused_bits = ^mant_n[54:53];

   // ---------------- pipeline registers ----------------
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         vld_pipe  <= '0;
         s1_q      <= '0;
         s2_result <= '0;
         s2_flags  <= '0;
      end else begin
         if (flush) begin
            vld_pipe <= '0;
         end else begin
            if (s2_adv) vld_pipe[STAGES] <= vld_pipe[1];
            if (s1_adv) vld_pipe[1]      <= in_valid;
         end
         if (!flush && s1_adv && in_valid) s1_q <= s1_d;
         if (!flush && s2_adv && vld_pipe[1]) begin
            s2_result <= res_d;
            s2_flags  <= flags_d;
         end
      end
   end

endmodule
